// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B operand registers, shifter, ALU, C register and Z/N/V flags.
// One operation per valid/ready handshake; the internal FSM runs read-A, read-B, execute and write-back.
module datapath_seq #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int IMMW     = 5,
    parameter int SEXT_IMM = 0,
    localparam int RW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             ext,
    input  logic [RW-1:0]    rn,
    input  logic [RW-1:0]    rm,
    input  logic [RW-1:0]    rd,
    input  logic [1:0]       shift,
    input  logic [1:0]       alu_op,
    input  logic             asel,
    input  logic             bsel,
    input  logic [IMMW-1:0]  imm,
    input  logic             wb,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] ext_data,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Z_out,
    output logic             N_out,
    output logic             V_out
);

    // Handshake: an operation is taken on any rising edge where op_valid and
    // op_ready are both high; op_ready is high only in IDLE and never during reset.
    typedef enum logic [2:0] {IDLE, RDA, RDB, EXE, WB} state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] a_reg, b_reg, c_reg;
    logic             z_reg, n_reg, v_reg, done_reg;

    logic             ext_q, asel_q, bsel_q, wb_q, set_flags_q;
    logic [RW-1:0]    rn_q, rm_q, rd_q;
    logic [1:0]       shift_q, alu_op_q;
    logic [IMMW-1:0]  imm_q;
    logic [WIDTH-1:0] ext_data_q;

    logic [WIDTH-1:0] imm_ext, b_shift, ain, bin, alu_out;
    logic             alu_v;
    logic             accept;

    assign op_ready = (state == IDLE) && !reset;
    assign accept   = op_valid && op_ready;
    assign done     = done_reg;
    assign result   = c_reg;
    assign Z_out    = z_reg;
    assign N_out    = n_reg;
    assign V_out    = v_reg;

    always_comb begin
        imm_ext = (SEXT_IMM != 0) ? {{(WIDTH-IMMW){imm_q[IMMW-1]}}, imm_q}
                                  : {{(WIDTH-IMMW){1'b0}}, imm_q};
        case (shift_q)
            2'b01:   b_shift = {b_reg[WIDTH-2:0], 1'b0};
            2'b10:   b_shift = {1'b0, b_reg[WIDTH-1:1]};
            2'b11:   b_shift = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
            default: b_shift = b_reg;
        endcase
        ain = asel_q ? '0 : a_reg;
        bin = bsel_q ? imm_ext : b_shift;
        alu_out = '0;
        alu_v   = 1'b0;
        // Overflow is judged on the operands actually presented to the ALU.
        case (alu_op_q)
            2'b00: begin
                alu_out = ain + bin;
                alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b01: begin
                alu_out = ain - bin;
                alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            z_reg       <= 1'b0;
            n_reg       <= 1'b0;
            v_reg       <= 1'b0;
            done_reg    <= 1'b0;
            ext_q       <= 1'b0;
            asel_q      <= 1'b0;
            bsel_q      <= 1'b0;
            wb_q        <= 1'b0;
            set_flags_q <= 1'b0;
            rn_q        <= '0;
            rm_q        <= '0;
            rd_q        <= '0;
            shift_q     <= '0;
            alu_op_q    <= '0;
            imm_q       <= '0;
            ext_data_q  <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ext_q       <= ext;
                        asel_q      <= asel;
                        bsel_q      <= bsel;
                        wb_q        <= wb;
                        set_flags_q <= set_flags;
                        rn_q        <= rn;
                        rm_q        <= rm;
                        rd_q        <= rd;
                        shift_q     <= shift;
                        alu_op_q    <= alu_op;
                        imm_q       <= imm;
                        ext_data_q  <= ext_data;
                        // done is registered, so it is raised on the edge entering WB.
                        state       <= ext ? WB : RDA;
                        done_reg    <= ext;
                    end
                end
                RDA: begin
                    a_reg <= regs[rn_q];
                    state <= RDB;
                end
                RDB: begin
                    b_reg <= regs[rm_q];
                    state <= EXE;
                end
                EXE: begin
                    c_reg <= alu_out;
                    if (set_flags_q) begin
                        z_reg <= (alu_out == '0);
                        n_reg <= alu_out[WIDTH-1];
                        v_reg <= alu_v;
                    end
                    state    <= WB;
                    done_reg <= 1'b1;
                end
                WB: begin
                    if (ext_q)     regs[rd_q] <= ext_data_q;
                    else if (wb_q) regs[rd_q] <= c_reg;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised, self-sequencing successor to the lab datapath: register file, A/B operand registers, shifter, ALU, C result register, status flags.
- Width, register count and immediate width are configurable. An internal FSM accepts one operation per valid/ready handshake and runs read-A, read-B, execute and write-back itself, so the controller no longer drives loada/loadb/loadc/write each cycle.
- Adds N/V flags, sign-extended immediates and an external-load path. Sits between the instruction decoder and memory/IO.

Parameters:
WIDTH, 16, datapath and register width (>=4)
NREGS, 8, number of general registers (power of 2, >=2); RW = log2(NREGS)
IMMW, 5, immediate field width (< WIDTH)
SEXT_IMM, 0, 1 = sign-extend the immediate, 0 = zero-extend it

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
op_valid  in  1  operation request
op_ready  out  1  high when the block can accept an operation
ext  in  1  1 = external load (write ext_data to rd), 0 = ALU operation
rn  in  RW  source register for A
rm  in  RW  source register for B
rd  in  RW  destination register
shift  in  2  B shifter: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
alu_op  in  2  00 A+B, 01 A-B, 10 A&B, 11 ~B
asel  in  1  1 = Ain is 0
bsel  in  1  1 = Bin is the extended imm (bypasses the shifter)
imm  in  IMMW  immediate
wb  in  1  write C to rd at the end of the operation
set_flags  in  1  update Z/N/V in EXE
ext_data  in  WIDTH  external load data
done  out  1  one-cycle pulse when the operation completes
result  out  WIDTH  C register
Z_out  out  1  zero flag
N_out  out  1  negative flag
V_out  out  1  signed-overflow flag

Behaviour:
- Reset (synchronous, active-high) clears:
  - FSM to IDLE;
  - all NREGS registers, A, B and C to 0;
  - Z, N and V to 0; done to 0.
- Reset mid-operation aborts it: no register write, no done. op_ready is 0 during the reset cycle.
- op_ready = (state==IDLE) && !reset. Accept = op_valid && op_ready. On accept, every input field is captured; later input changes are ignored.
- FSM states: IDLE, RDA, RDB, EXE, WB.
  - IDLE: on accept with ext=0 go to RDA; with ext=1 go to WB; otherwise stay.
  - RDA: A <= R[rn]; go to RDB.
  - RDB: B <= R[rm]; go to EXE.
  - EXE: compute the ALU result and load it into C; if set_flags, load flags; go to WB.
  - WB: done=1. If ext, R[rd] <= captured ext_data (C and flags unchanged). Else if wb, R[rd] <= C. Go to IDLE.
- Latency: accepted in cycle T; ALU op completes with done in T+4 (result valid from T+4); ext op completes with done in T+1. Register write takes effect at the end of the done cycle.
- Throughput: the next op can be accepted in the cycle after done, so back-to-back ALU ops occupy 5 cycles each.
- Operands:
  - Ain = asel ? 0 : A.
  - Bin = bsel ? ext(imm) : shift(B), where ext() follows SEXT_IMM.
- Arithmetic is modulo 2^WIDTH.
- Flags:
  - Z = (out==0); N = out[WIDTH-1].
  - V: add = operand signs equal and result sign differs; sub = operand signs differ and result sign differs from Ain; and/not = 0.
- Hazards: reads see register values as written at the end of earlier WB cycles. There is no forwarding; none is needed because ops are serialised.
- rn==rm==rd is legal.
- op_valid while busy is ignored. The requester must hold op_valid until accepted.

Test Plan:
- Reset, then ext loads R0=7 and R1=2 (2 cycles each, done at T+1); op ADD rd=2, rn=0, rm=1, wb=1, set_flags=1 -> done at T+4, result=9, R2=9, Z=0, N=0, V=0.
- WIDTH=16: R0=0x7FFF, R1=1; ADD set_flags -> result=0x8000, N=1, V=1, Z=0. Then SUB R1-R1 -> result=0, Z=1, V=0.
- Shifts on R1=0x8001:
  - shift=01 with ~B -> result = ~0x0002 = 0xFFFD;
  - shift=11 ASR1 -> B path value 0xC000;
  - shift=10 LSR1 -> 0x4000.
- Immediate mode: bsel=1, asel=1, imm=5'b11111, alu_op=00 -> result 0x001F with SEXT_IMM=0, 0xFFFF with SEXT_IMM=1.
- Handshake: hold op_valid high continuously -> op_ready drops for 4 cycles per ALU op, ops are accepted exactly once each, and a changed rd mid-op has no effect. wb=0 -> C updates, register file unchanged.
- Reset asserted in EXE -> no done pulse, rd unchanged, all registers and flags 0, op_ready=1 the cycle after reset deasserts.
